// File: rtl/ui_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ui_pkg
//  Description : Constants and types shared by the front-panel UI blocks.
//                Holds the 12 MHz clock rate, default debounce/autorepeat
//                cycle counts derived from millisecond figures, the
//                autorepeat state encoding and small width helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package ui_pkg;

  localparam int CLK_HZ = 12_000_000;

  localparam int c_DEB_MS       = 10;
  localparam int c_REP_DELAY_MS = 500;
  localparam int c_REP_RATE_MS  = 100;

  localparam int c_DEB_CYCLES_DFLT       = (CLK_HZ / 1000) * c_DEB_MS;        // 120000
  localparam int c_REP_DELAY_CYCLES_DFLT = (CLK_HZ / 1000) * c_REP_DELAY_MS;  // 6000000
  localparam int c_REP_RATE_CYCLES_DFLT  = (CLK_HZ / 1000) * c_REP_RATE_MS;   // 1200000

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a counter that must hold 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_ch
//  Description : One button channel: 2-FF synchroniser, counter debounce,
//                single-cycle press/release strobes and, when the macro
//                BTN_AUTOREPEAT_EN is defined, a hold-to-repeat FSM.
//                Without the macro btn_evt is simply btn_press.
//  Ports       : CLK12       in   system clock
//                rst_n       in   asynchronous active-low reset
//                btn_in      in   polarity-corrected pin (1 = pressed), async
//                btn_level   out  debounced level
//                btn_press   out  1-cycle strobe, first cycle of level = 1
//                btn_release out  1-cycle strobe, first cycle of level = 0
//                btn_evt     out  press strobe OR autorepeat strobe
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce_ch
  import ui_pkg::*;
#(
  parameter int DEB_CYCLES       = c_DEB_CYCLES_DFLT,
  parameter int REP_DELAY_CYCLES = c_REP_DELAY_CYCLES_DFLT,
  parameter int REP_RATE_CYCLES  = c_REP_RATE_CYCLES_DFLT
) (
  input  logic CLK12,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_evt
);

  if (DEB_CYCLES < 2 || REP_DELAY_CYCLES < 1 || REP_RATE_CYCLES < 1) begin : g_param_check
    $error("btn_debounce_ch: DEB_CYCLES must be >= 2 and REP_* cycles >= 1");
  end

  localparam int               c_DW       = $clog2(DEB_CYCLES);
  localparam logic [c_DW-1:0]  c_DEB_LAST = c_DW'(DEB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic [c_DW-1:0] r_dcnt;
  logic            r_press;
  logic            r_release;

  // A change is accepted on the DEB_CYCLES-th consecutive differing sample.
  logic w_accept;
  logic w_press_edge;
  logic w_release_edge;

  assign w_accept       = (r_sync2 != r_stable) && (r_dcnt == c_DEB_LAST);
  assign w_press_edge   = w_accept &  r_sync2;
  assign w_release_edge = w_accept & ~r_sync2;

  always_ff @(posedge CLK12 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_stable  <= 1'b0;
      r_dcnt    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= btn_in;
      r_sync2   <= r_sync1;
      r_press   <= w_press_edge;
      r_release <= w_release_edge;
      if (r_sync2 == r_stable) begin
        r_dcnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_dcnt   <= '0;
      end else begin
        // Cannot pass c_DEB_LAST: reaching it while differing is an accept.
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

  assign btn_level   = r_stable;
  assign btn_press   = r_press;
  assign btn_release = r_release;

`ifdef BTN_AUTOREPEAT_EN
  localparam int               c_RW         = cnt_width(max_int(REP_DELAY_CYCLES, REP_RATE_CYCLES));
  localparam logic [c_RW-1:0]  c_DELAY_LAST = c_RW'(REP_DELAY_CYCLES - 1);
  localparam logic [c_RW-1:0]  c_RATE_LAST  = c_RW'(REP_RATE_CYCLES - 1);

  rep_state_t      r_state;
  rep_state_t      w_state_nxt;
  logic [c_RW-1:0] r_rcnt;
  logic [c_RW-1:0] w_rcnt_nxt;
  logic            r_rep;
  logic            w_rep_nxt;

  always_ff @(posedge CLK12 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_rep   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_rep   <= w_rep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rep_nxt   = 1'b0;
    if (w_release_edge) begin
      // Release wins over a repeat falling due in the same cycle.
      w_state_nxt = IDLE;
      w_rcnt_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_press_edge) begin
            w_state_nxt = DELAY;
            w_rcnt_nxt  = '0;
          end
        end
        DELAY: begin
          if (r_rcnt == c_DELAY_LAST) begin
            w_rep_nxt   = 1'b1;
            w_state_nxt = REPEAT;
            w_rcnt_nxt  = '0;
          end else if (r_rcnt != '1) begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
        REPEAT: begin
          if (r_rcnt == c_RATE_LAST) begin
            w_rep_nxt  = 1'b1;
            w_rcnt_nxt = '0;
          end else if (r_rcnt != '1) begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_rcnt_nxt  = '0;
        end
      endcase
    end
  end

  // A repeat is never issued in the press cycle (FSM is still IDLE then).
  assign btn_evt = r_press | r_rep;
`else
  assign btn_evt = r_press;
`endif

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Front-panel button conditioner for the LCD UI controller.
//                Corrects pin polarity, then runs N_BTN independent
//                debounce/strobe/autorepeat channels. Autorepeat is built
//                only when the macro BTN_AUTOREPEAT_EN is defined.
//  Ports       : CLK12       in   12 MHz system clock
//                rst_n       in   asynchronous active-low reset
//                btn_raw     in   raw button pins [N_BTN], asynchronous
//                btn_level   out  debounced levels, 1 = pressed
//                btn_press   out  1-cycle press strobes
//                btn_release out  1-cycle release strobes
//                btn_evt     out  UI step input: press or autorepeat
//                any_pressed out  OR of btn_level
//  Revision    : 1.0  initial release
// ============================================================================
module btn_conditioner
  import ui_pkg::*;
#(
  parameter int N_BTN            = 4,
  parameter int ACTIVE_LOW_IN    = 1,
  parameter int DEB_CYCLES       = c_DEB_CYCLES_DFLT,
  parameter int REP_DELAY_CYCLES = c_REP_DELAY_CYCLES_DFLT,
  parameter int REP_RATE_CYCLES  = c_REP_RATE_CYCLES_DFLT
) (
  input  logic             CLK12,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_evt,
  output logic             any_pressed
);

  logic [N_BTN-1:0] w_btn_pressed;

  if (ACTIVE_LOW_IN != 0) begin : g_pol_inv
    assign w_btn_pressed = ~btn_raw;
  end else begin : g_pol_pass
    assign w_btn_pressed = btn_raw;
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYCLES       (DEB_CYCLES),
      .REP_DELAY_CYCLES (REP_DELAY_CYCLES),
      .REP_RATE_CYCLES  (REP_RATE_CYCLES)
    ) u_ch (
      .CLK12       (CLK12),
      .rst_n       (rst_n),
      .btn_in      (w_btn_pressed[gi]),
      .btn_level   (btn_level[gi]),
      .btn_press   (btn_press[gi]),
      .btn_release (btn_release[gi]),
      .btn_evt     (btn_evt[gi])
    );
  end

  assign any_pressed = |btn_level;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_conditioner
//  Description : Self-checking bench for btn_conditioner. A pin-level
//                reference model (sliding window over sampled pins, repeat
//                times computed arithmetically from the press time) is
//                compared against the DUT every cycle, plus directed checks
//                for reset, bounce, autorepeat, simultaneous presses and
//                asynchronous reset. Honours BTN_AUTOREPEAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_conditioner;

  localparam int c_N   = 4;
  localparam int c_DEB = 4;
  localparam int c_RD  = 20;
  localparam int c_RR  = 8;
`ifdef BTN_AUTOREPEAT_EN
  localparam int c_EXP_HOLD_EVT = 6;
`else
  localparam int c_EXP_HOLD_EVT = 1;
`endif

  logic           CLK12 = 1'b0;
  logic           rst_n;
  logic [c_N-1:0] btn_raw;
  logic [c_N-1:0] btn_level;
  logic [c_N-1:0] btn_press;
  logic [c_N-1:0] btn_release;
  logic [c_N-1:0] btn_evt;
  logic           any_pressed;

  btn_conditioner #(
    .N_BTN            (c_N),
    .ACTIVE_LOW_IN    (1),
    .DEB_CYCLES       (c_DEB),
    .REP_DELAY_CYCLES (c_RD),
    .REP_RATE_CYCLES  (c_RR)
  ) u_dut (
    .CLK12       (CLK12),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_evt     (btn_evt),
    .any_pressed (any_pressed)
  );

  always #5 CLK12 = ~CLK12;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_hist[ch][k] = pressed value sampled k edges ago (k=0 is this edge).
  // A change is accepted when the synchronised value seen over the last
  // DEB edges (pins from 2 .. DEB+1 edges ago) all differ from the level.
  bit     m_hist   [c_N][8];
  bit     m_stable [c_N];
  bit     m_press  [c_N];
  bit     m_rel    [c_N];
  bit     m_rep    [c_N];
  longint m_tp     [c_N];
  longint m_t;

  task automatic model_reset();
    for (int c = 0; c < c_N; c++) begin
      for (int k = 0; k < 8; k++) m_hist[c][k] = 1'b0;
      m_stable[c] = 1'b0;
      m_press[c]  = 1'b0;
      m_rel[c]    = 1'b0;
      m_rep[c]    = 1'b0;
      m_tp[c]     = 0;
    end
  endtask

  task automatic model_edge();
    bit     all_diff;
    bit     nxt;
    longint d;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_t++;
      for (int c = 0; c < c_N; c++) begin
        for (int k = 7; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = ~btn_raw[c];
        all_diff = 1'b1;
        for (int k = 2; k <= c_DEB + 1; k++)
          if (m_hist[c][k] == m_stable[c]) all_diff = 1'b0;
        nxt = all_diff ? ~m_stable[c] : m_stable[c];
        m_press[c] = ~m_stable[c] & nxt;
        m_rel[c]   = m_stable[c] & ~nxt;
        m_rep[c]   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        d = m_t - m_tp[c];
        if (m_stable[c] && nxt && d >= c_RD && ((d - c_RD) % c_RR) == 0)
          m_rep[c] = 1'b1;
`else
        d = 0;
`endif
        if (m_press[c]) m_tp[c] = m_t;
        m_stable[c] = nxt;
      end
    end
  endtask

  function automatic logic [c_N-1:0] pack(input bit v [c_N]);
    logic [c_N-1:0] r;
    for (int c = 0; c < c_N; c++) r[c] = v[c];
    return r;
  endfunction

  task automatic compare_all();
    logic [c_N-1:0] e_lvl;
    logic [c_N-1:0] e_prs;
    logic [c_N-1:0] e_rel;
    logic [c_N-1:0] e_rep;
    e_lvl = pack(m_stable);
    e_prs = pack(m_press);
    e_rel = pack(m_rel);
    e_rep = pack(m_rep);
    check_val("level",   32'(btn_level),   32'(e_lvl));
    check_val("press",   32'(btn_press),   32'(e_prs));
    check_val("release", 32'(btn_release), 32'(e_rel));
    check_val("evt",     32'(btn_evt),     32'(e_prs | e_rep));
    check_val("any",     32'(any_pressed), 32'(|e_lvl));
  endtask

  // One clock: model follows the active edge, DUT is checked on the falling edge.
  task automatic tick();
    @(posedge CLK12);
    model_edge();
    @(negedge CLK12);
    compare_all();
  endtask

  // Cycles until btn_press[ch] is seen, or -1 if it never arrives.
  task automatic wait_press(input int ch, output int cnt);
    int  n;
    bit  found;
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      tick();
      n++;
      if (btn_press[ch]) found = 1'b1;
    end
    cnt = found ? n : -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt_a;
    int cnt_b;
    bit seen;
    int hold [c_N];

    m_t     = 0;
    rst_n   = 1'b0;
    btn_raw = 4'b1110;
    model_reset();

    // Reset held with button 0 pressed: nothing may come out.
    repeat (5) tick();
    check_val("rst_zero", {btn_level, btn_press, btn_release, btn_evt, any_pressed}, 32'd0);
    rst_n = 1'b1;
    wait_press(0, lat);
    check_val("rst_lat", lat, 32'd6);
    btn_raw[0] = 1'b1;
    repeat (10) tick();

    // Bounce on button 1, then a clean hold.
    cnt_a = 0;
    for (int i = 0; i < 10; i++) begin
      btn_raw[1] = ~btn_raw[1];
      repeat (2) begin
        tick();
        if (btn_press[1] || btn_release[1]) cnt_a++;
      end
    end
    check_val("bounce_quiet", cnt_a, 32'd0);
    btn_raw[1] = 1'b0;
    wait_press(1, lat);
    check_val("bounce_lat", lat, 32'd6);
    btn_raw[1] = 1'b1;
    repeat (10) tick();

    // Hold button 2 for 60 cycles from acceptance.
    btn_raw[2] = 1'b0;
    wait_press(2, lat);
    check_val("hold_lat", lat, 32'd6);
    cnt_a = btn_evt[2] ? 1 : 0;
    repeat (59) begin
      tick();
      if (btn_evt[2]) cnt_a++;
    end
    check_val("hold_evts", cnt_a, c_EXP_HOLD_EVT);
    btn_raw[2] = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    seen  = 1'b0;
    repeat (30) begin
      tick();
      if (btn_release[2]) begin
        cnt_a++;
        seen = 1'b1;
      end
      if (seen && btn_evt[2]) cnt_b++;
    end
    check_val("hold_rel", cnt_a, 32'd1);
    check_val("hold_post_evt", cnt_b, 32'd0);

    // Buttons 0 and 3 together.
    btn_raw = 4'b0110;
    cnt_a = 0;
    while (btn_press == '0 && cnt_a < 20) begin
      tick();
      cnt_a++;
    end
    check_val("simul_press", 32'(btn_press), 32'h9);
    repeat (10) tick();
    btn_raw[0] = 1'b1;
    repeat (10) tick();
    check_val("simul_any_hold", 32'(any_pressed), 32'd1);
    btn_raw[3] = 1'b1;
    repeat (10) tick();
    check_val("simul_any_off", 32'(any_pressed), 32'd0);

    // Asynchronous reset in the middle of a long hold.
    btn_raw[2] = 1'b0;
    wait_press(2, lat);
    repeat (30) tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("arst_clear", {btn_level, btn_press, btn_release, btn_evt, any_pressed}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_press(2, lat);
    check_val("arst_relat", lat, 32'd6);
    btn_raw[2] = 1'b1;
    repeat (10) tick();

    // Random holds and short bounces on every channel.
    for (int c = 0; c < c_N; c++) hold[c] = $urandom_range(1, 30);
    repeat (700) begin
      for (int c = 0; c < c_N; c++) begin
        if (hold[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
        end else begin
          hold[c]--;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
